// File: rtl/backlight_fade_ctrl_pkg.sv
// Shared types and widths for the backlight fade controller and its helpers.
package backlight_fade_ctrl_pkg;
  localparam int DUTY_W = 5;
  localparam int IDLE_W = 16;

  typedef enum logic {
    FADE    = 1'b0,
    SETTLED = 1'b1
  } state_t;
endpackage

// File: rtl/backlight_fade_ctrl_if.sv
// Strobe inputs and registered duty/status outputs of the fade controller.
interface backlight_fade_ctrl_if;
  import backlight_fade_ctrl_pkg::*;

  logic [DUTY_W-1:0] Target_Val;
  logic              Target_Load;
  logic              Activity;
  logic [DUTY_W-1:0] Duty_Val;
  logic              Busy;
  logic              Dimmed;

  modport master (
    output Target_Val, Target_Load, Activity,
    input  Duty_Val, Busy, Dimmed
  );

  modport slave (
    input  Target_Val, Target_Load, Activity,
    output Duty_Val, Busy, Dimmed
  );
endinterface

// File: rtl/backlight_fade_ctrl_tick_gen.sv
// Free-running prescaler: counts DIV-1 down to 0, pulses tick while at 0, reloads.
module bl_tick_gen #(
  parameter int DIV = 64
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);
  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                r_cnt <= RELOAD;
    else if (r_cnt == '0)   r_cnt <= RELOAD;
    else                    r_cnt <= r_cnt - 1'b1;
  end

  assign tick = (r_cnt == '0);
endmodule

// File: rtl/backlight_fade_ctrl.sv
// Backlight duty ramp: one step per prescaler tick toward the user target,
// with auto-dim to DIM_LEVEL after IDLE_TICKS settled ticks of inactivity.
module backlight_fade_ctrl
  import backlight_fade_ctrl_pkg::*;
#(
  parameter int                FADE_DIV       = 64,
  parameter logic [IDLE_W-1:0] IDLE_TICKS     = 16'd60000,
  parameter logic [DUTY_W-1:0] DIM_LEVEL      = 5'd4,
  parameter logic [DUTY_W-1:0] DEFAULT_TARGET = 5'd31
) (
  input  logic                 CLK,
  input  logic                 RST,
  backlight_fade_ctrl_if.slave bus
);
  // A zero default target means the block is already at its goal out of reset.
  localparam state_t RST_STATE = (DEFAULT_TARGET != '0) ? FADE : SETTLED;

  logic              w_tick;
  logic              w_strobe;
  logic [DUTY_W-1:0] w_goal;

  state_t            r_state,  w_state_nxt;
  logic [DUTY_W-1:0] r_duty,   w_duty_nxt;
  logic [DUTY_W-1:0] r_target;
  logic              r_dimmed, w_dimmed_nxt;
  logic [IDLE_W-1:0] r_idle,   w_idle_nxt;

  bl_tick_gen #(.DIV(FADE_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (w_tick)
  );

  assign w_strobe = bus.Target_Load | bus.Activity;
  assign w_goal   = (r_dimmed && (r_target > DIM_LEVEL)) ? DIM_LEVEL : r_target;

  always_comb begin
    w_state_nxt  = (r_duty != w_goal) ? FADE : SETTLED;
    w_duty_nxt   = r_duty;
    w_dimmed_nxt = r_dimmed;
    w_idle_nxt   = r_idle;

    if (w_tick && (r_state == FADE) && (r_duty != w_goal))
      w_duty_nxt = (w_goal > r_duty) ? r_duty + 1'b1 : r_duty - 1'b1;

    // Strobes outrank a timeout landing in the same cycle.
    if (w_strobe) begin
      w_dimmed_nxt = 1'b0;
      w_idle_nxt   = '0;
    end else if (w_tick && (r_state == SETTLED) && !r_dimmed) begin
      if ((r_idle + 1'b1) == IDLE_TICKS) begin
        w_idle_nxt   = '0;
        w_dimmed_nxt = 1'b1;
      end else begin
        w_idle_nxt   = r_idle + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= RST_STATE;
      r_duty   <= '0;
      r_target <= DEFAULT_TARGET;
      r_dimmed <= 1'b0;
      r_idle   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_duty   <= w_duty_nxt;
      r_dimmed <= w_dimmed_nxt;
      r_idle   <= w_idle_nxt;
      if (bus.Target_Load) r_target <= bus.Target_Val;
    end
  end

  assign bus.Duty_Val = r_duty;
  assign bus.Dimmed   = r_dimmed;
  assign bus.Busy     = (r_state == FADE);
endmodule

// File: tb/tb_backlight_fade_ctrl.sv
// Directed + random bench for backlight_fade_ctrl against a cycle-level reference model.
module tb_backlight_fade_ctrl;
  import backlight_fade_ctrl_pkg::*;

  localparam int DIV  = 4;
  localparam int IDLE = 8;
  localparam int DIM  = 4;
  localparam int DEF  = 31;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  backlight_fade_ctrl_if bus();

  backlight_fade_ctrl #(
    .FADE_DIV       (DIV),
    .IDLE_TICKS     (16'(IDLE)),
    .DIM_LEVEL      (5'(DIM)),
    .DEFAULT_TARGET (5'(DEF))
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: edge count since reset release, duty, target, idle ticks, dim flag,
  // and the one-cycle-late busy flag.
  int m_edge, m_duty, m_tgt, m_idle;
  bit m_dim, m_busy;

  function automatic int m_goal();
    if (m_dim) return (m_tgt < DIM) ? m_tgt : DIM;
    return m_tgt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0; m_duty = 0; m_tgt = DEF; m_idle = 0; m_dim = 0;
    m_busy = (DEF != 0);
  endtask

  // One clock: drive strobes, advance model, compare after the edge.
  task automatic step(input logic ld, input logic [4:0] v, input logic act);
    bit tick, nb;
    int goal;
    bus.Target_Load = ld;
    bus.Target_Val  = v;
    bus.Activity    = act;
    m_edge++;
    tick = ((m_edge % DIV) == 0);
    goal = m_goal();
    nb   = (m_duty != goal);
    if (tick && m_busy && (m_duty != goal)) m_duty += (goal > m_duty) ? 1 : -1;
    if (ld || act) begin
      m_dim = 0; m_idle = 0;
    end else if (tick && !m_busy && !m_dim) begin
      m_idle++;
      if (m_idle == IDLE) begin m_idle = 0; m_dim = 1; end
    end
    if (ld) m_tgt = v;
    m_busy = nb;
    @(posedge CLK); #1;
    bus.Target_Load = 1'b0;
    bus.Activity    = 1'b0;
    chk("duty",   bus.Duty_Val, m_duty);
    chk("busy",   bus.Busy,     m_busy);
    chk("dimmed", bus.Dimmed,   m_dim);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    #1;
    chk("rst_duty", bus.Duty_Val, 0);
    chk("rst_busy", bus.Busy,     1);
    chk("rst_dim",  bus.Dimmed,   0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic settle(output int nd, output int nu);
    int prev;
    nd = 0; nu = 0;
    for (int k = 0; k < 400; k++) begin
      if (!m_busy && (m_duty == m_goal())) break;
      prev = int'(bus.Duty_Val);
      step(1'b0, 5'd0, 1'b0);
      if (int'(bus.Duty_Val) == prev - 1) nd++;
      if (int'(bus.Duty_Val) == prev + 1) nu++;
    end
    chk("settled_busy", bus.Busy, 0);
  endtask

  initial begin
    int  nd, nu;
    bit  found, busy_seen;

    bus.Target_Val  = 5'd0;
    bus.Target_Load = 1'b0;
    bus.Activity    = 1'b0;
    #2;
    apply_reset();

    // Soft power-on ramp 0 -> 31.
    while (m_edge < 123) step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    chk("pwr_124_duty", bus.Duty_Val, 31);
    chk("pwr_124_busy", bus.Busy, 1);
    step(1'b0, 5'd0, 1'b0);
    chk("pwr_125_busy", bus.Busy, 0);

    // Idle timeout after 8 settled ticks, dim ramp to 4.
    while (m_edge < 155) step(1'b0, 5'd0, 1'b0);
    chk("dim_155", bus.Dimmed, 0);
    step(1'b0, 5'd0, 1'b0);
    chk("dim_156", bus.Dimmed, 1);
    while (m_edge < 263) step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    chk("dim_264_duty", bus.Duty_Val, 4);
    chk("dim_264_busy", bus.Busy, 1);
    step(1'b0, 5'd0, 1'b0);
    chk("dim_265_busy", bus.Busy, 0);

    // Activity wakes up; then dim again and interrupt the ramp at 20.
    step(1'b0, 5'd0, 1'b1);
    chk("wake_dim", bus.Dimmed, 0);
    settle(nd, nu);
    chk("wake_up_steps", nu, 27);
    chk("wake_duty", bus.Duty_Val, 31);
    found = 0;
    for (int k = 0; k < 600; k++) begin
      if (m_dim && m_duty == 20) begin found = 1; break; end
      step(1'b0, 5'd0, 1'b0);
    end
    chk("reach20", found, 1);
    step(1'b0, 5'd0, 1'b1);
    chk("rev_dim", bus.Dimmed, 0);
    for (int k = 0; k < 8; k++) begin
      if (bus.Duty_Val != 5'd20) break;
      step(1'b0, 5'd0, 1'b0);
    end
    chk("rev_first", bus.Duty_Val, 21);
    settle(nd, nu);
    chk("rev_top", bus.Duty_Val, 31);

    // Load 10, plain and with coincident Activity.
    step(1'b1, 5'd10, 1'b0);
    settle(nd, nu);
    chk("ld10_dn", nd, 21);
    chk("ld10_duty", bus.Duty_Val, 10);
    step(1'b1, 5'd31, 1'b0);
    settle(nd, nu);
    step(1'b1, 5'd10, 1'b1);
    settle(nd, nu);
    chk("ld10act_dn", nd, 21);
    chk("ld10act_duty", bus.Duty_Val, 10);
    chk("ld10act_dim", bus.Dimmed, 0);

    // Target below DIM_LEVEL: timeout dims without moving.
    step(1'b1, 5'd2, 1'b0);
    settle(nd, nu);
    busy_seen = 0;
    for (int k = 0; k < 64; k++) begin
      if (m_dim) break;
      step(1'b0, 5'd0, 1'b0);
      busy_seen |= bus.Busy;
    end
    chk("low_dim", bus.Dimmed, 1);
    chk("low_duty", bus.Duty_Val, 2);
    chk("low_busy_seen", busy_seen, 0);

    // Loading the current duty value must not raise Busy.
    step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd2, 1'b0);
    busy_seen = 0;
    repeat (6) begin
      step(1'b0, 5'd0, 1'b0);
      busy_seen |= bus.Busy;
    end
    chk("eq_busy_seen", busy_seen, 0);

    // Strobe on the timeout edge keeps Dimmed low (Activity, then Target_Load).
    for (int v = 0; v < 2; v++) begin
      found = 0;
      for (int k = 0; k < 200; k++) begin
        if (m_idle == IDLE - 1 && !m_busy && !m_dim && m_duty == m_goal() &&
            ((m_edge + 1) % DIV) == 0) begin found = 1; break; end
        step(1'b0, 5'd0, 1'b0);
      end
      chk("race_found", found, 1);
      if (v == 0) step(1'b0, 5'd0, 1'b1);
      else        step(1'b1, 5'd2, 1'b0);
      chk("race_dim", bus.Dimmed, 0);
    end

    // Async reset mid-ramp at 15.
    apply_reset();
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_duty == 15 && m_busy) begin found = 1; break; end
      step(1'b0, 5'd0, 1'b0);
    end
    chk("reach15", found, 1);
    apply_reset();
    repeat (3) step(1'b0, 5'd0, 1'b0);
    chk("rst_e3_duty", bus.Duty_Val, 0);
    step(1'b0, 5'd0, 1'b0);
    chk("rst_e4_duty", bus.Duty_Val, 1);

    // Random strobes.
    repeat (1200)
      step($urandom_range(0, 31) == 0, 5'($urandom), $urandom_range(0, 23) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
